// File: rtl/vibration_window_stats_if.sv
// ---------------------------------------------------------------------------
// vibration_window_stats_if
// Bundles the sample stream, control inputs and window result outputs of
// vibration_window_stats.
//   in_valid     : sample strobe (rising edge = one sample)
//   in_data      : signed 8-bit acceleration sample
//   enable       : accept samples when high, abort window when low
//   alarm_clr    : synchronous clear of the sticky alarm
//   win_valid    : one-cycle pulse, new window results
//   win_p2p      : window peak-to-peak (max - min), unsigned 9 bits
//   win_mean_abs : window mean of |sample|, unsigned 8 bits
//   win_count    : completed window counter, wraps at 2^16
//   alarm        : sticky peak-to-peak alarm
// master = sample producer / result consumer, slave = the statistics block.
// ---------------------------------------------------------------------------
interface vibration_window_stats_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        enable;
  logic        alarm_clr;
  logic        win_valid;
  logic [8:0]  win_p2p;
  logic [7:0]  win_mean_abs;
  logic [15:0] win_count;
  logic        alarm;

  modport master (
    output in_valid, in_data, enable, alarm_clr,
    input  win_valid, win_p2p, win_mean_abs, win_count, alarm
  );

  modport slave (
    input  in_valid, in_data, enable, alarm_clr,
    output win_valid, win_p2p, win_mean_abs, win_count, alarm
  );
endinterface

// File: rtl/vibration_window_stats.sv
// ---------------------------------------------------------------------------
// vibration_window_stats
// Collects fixed-length windows of 2^WINDOW_LOG2 accelerometer samples and
// reports peak-to-peak, mean absolute value and a window count, plus a
// sticky alarm when a window's peak-to-peak reaches THRESHOLD.
// Ports:
//   sys_clock : single clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : vibration_window_stats_if.slave (samples in, results out)
// ---------------------------------------------------------------------------
module vibration_window_stats #(
  parameter int unsigned WINDOW_LOG2 = 4,
  parameter logic [8:0]  THRESHOLD   = 9'd40
) (
  input logic                      sys_clock,
  input logic                      reset,
  vibration_window_stats_if.slave  bus
);

  localparam int unsigned SUM_W = 8 + WINDOW_LOG2;
  // Index of the last sample in a window (N-1): all ones.
  localparam logic [WINDOW_LOG2-1:0] LAST_IDX = {WINDOW_LOG2{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Exact magnitude of a signed byte; -128 maps to 128 as an unsigned byte.
  function automatic logic [7:0] abs8(input logic [7:0] x);
    logic [7:0] r;
    if (x[7]) begin
      r = 8'd0 - x;
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic                   vld_prev_q;
  logic                   armed_q;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic signed [7:0]      max_q, max_d;
  logic signed [7:0]      min_q, min_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic                   win_valid_q, win_valid_d;
  logic [8:0]             p2p_q, p2p_d;
  logic [7:0]             mean_q, mean_d;
  logic [15:0]            count_q, count_d;
  logic                   alarm_q, alarm_d;

  logic signed [7:0]      sample_s;
  logic [7:0]             abs_s;
  logic                   accept_s;
  logic signed [7:0]      max_upd_s;
  logic signed [7:0]      min_upd_s;
  logic [SUM_W-1:0]       sum_upd_s;
  logic [8:0]             p2p_new_s;
  logic [7:0]             mean_new_s;
  logic                   emit_s;

  assign sample_s = bus.in_data;
  assign abs_s    = abs8(bus.in_data);
  // armed_q stays low after reset until in_valid has been seen low, so a
  // strobe already high at reset release is not mistaken for a new sample.
  assign accept_s = bus.enable & bus.in_valid & ~vld_prev_q & armed_q;

  // Running statistics including the current sample (used on accept in ACCUM).
  always_comb begin
    max_upd_s  = (sample_s > max_q) ? sample_s : max_q;
    min_upd_s  = (sample_s < min_q) ? sample_s : min_q;
    sum_upd_s  = sum_q + SUM_W'(abs_s);
    p2p_new_s  = {max_upd_s[7], max_upd_s} - {min_upd_s[7], min_upd_s};
    mean_new_s = sum_upd_s[SUM_W-1:WINDOW_LOG2];
  end

  // Next-state, accumulator, result and alarm logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    sum_d       = sum_q;
    win_valid_d = 1'b0;
    p2p_d       = p2p_q;
    mean_d      = mean_q;
    count_d     = count_q;
    emit_s      = 1'b0;

    if (!bus.enable) begin
      // Abort: partial window discarded, results and alarm hold.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, EMIT: begin
          if (accept_s) begin
            state_d = ACCUM;
            cnt_d   = WINDOW_LOG2'(1);
            max_d   = sample_s;
            min_d   = sample_s;
            sum_d   = SUM_W'(abs_s);
          end else begin
            state_d = IDLE;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            if (cnt_q == LAST_IDX) begin
              emit_s      = 1'b1;
              state_d     = EMIT;
              cnt_d       = '0;
              win_valid_d = 1'b1;
              p2p_d       = p2p_new_s;
              mean_d      = mean_new_s;
              count_d     = count_q + 16'd1;
            end else begin
              cnt_d = cnt_q + WINDOW_LOG2'(1);
              max_d = max_upd_s;
              min_d = min_upd_s;
              sum_d = sum_upd_s;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A set from a completing window has priority over a clear.
    if (emit_s && (p2p_new_s >= THRESHOLD)) begin
      alarm_d = 1'b1;
    end else if (bus.alarm_clr) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
  end

  // State, accumulator, edge-detect and output registers.
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vld_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      max_q       <= 8'sd0;
      min_q       <= 8'sd0;
      sum_q       <= '0;
      win_valid_q <= 1'b0;
      p2p_q       <= 9'd0;
      mean_q      <= 8'd0;
      count_q     <= 16'd0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_prev_q  <= bus.in_valid;
      armed_q     <= armed_q | ~bus.in_valid;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      sum_q       <= sum_d;
      win_valid_q <= win_valid_d;
      p2p_q       <= p2p_d;
      mean_q      <= mean_d;
      count_q     <= count_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.win_valid    = win_valid_q;
  assign bus.win_p2p      = p2p_q;
  assign bus.win_mean_abs = mean_q;
  assign bus.win_count    = count_q;
  assign bus.alarm        = alarm_q;

endmodule

// File: tb/tb_vibration_window_stats.sv
// ---------------------------------------------------------------------------
// tb_vibration_window_stats
// Randomized and directed stimulus against a sample-queue reference model of
// the windowed statistics; outputs compared every cycle, plus literal checks
// of hand-computed windows.
// ---------------------------------------------------------------------------
module tb_vibration_window_stats;

  localparam int WL  = 2;
  localparam int N   = 1 << WL;
  localparam int THR = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vibration_window_stats_if vif ();

  vibration_window_stats #(
    .WINDOW_LOG2 (WL),
    .THRESHOLD   (9'd40)
  ) dut (
    .sys_clock (clk),
    .reset     (rst_n),
    .bus       (vif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the current window is just a list of accepted samples.
  bit          m_prev;
  int          m_win[$];
  logic        m_valid;
  logic [8:0]  m_p2p;
  logic [7:0]  m_mean;
  logic [15:0] m_count;
  logic        m_alarm;

  // Captured results of the most recent window pulse.
  int          wins = 0;
  logic [8:0]  cap_p2p;
  logic [7:0]  cap_mean;
  logic [15:0] cap_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b1;  // a strobe high at reset release must first be seen low
    m_win.delete();
    m_valid = 1'b0;
    m_p2p   = 9'd0;
    m_mean  = 8'd0;
    m_count = 16'd0;
    m_alarm = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit set_alarm;
    int mx;
    int mn;
    int s;
    acc       = vif.enable && vif.in_valid && !m_prev;
    set_alarm = 1'b0;
    m_prev    = vif.in_valid;
    m_valid   = 1'b0;
    if (!vif.enable) begin
      m_win.delete();
    end else if (acc) begin
      m_win.push_back(int'($signed(vif.in_data)));
      if (m_win.size() == N) begin
        mx = -1000;
        mn = 1000;
        s  = 0;
        foreach (m_win[i]) begin
          if (m_win[i] > mx) mx = m_win[i];
          if (m_win[i] < mn) mn = m_win[i];
          s += (m_win[i] < 0) ? -m_win[i] : m_win[i];
        end
        m_p2p     = 9'(mx - mn);
        m_mean    = 8'(s / N);
        m_count   = m_count + 16'd1;
        m_valid   = 1'b1;
        set_alarm = ((mx - mn) >= THR);
        m_win.delete();
      end
    end
    if (set_alarm) m_alarm = 1'b1;
    else if (vif.alarm_clr) m_alarm = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("win_valid", 32'(vif.win_valid), 32'(m_valid));
      chk("win_p2p", 32'(vif.win_p2p), 32'(m_p2p));
      chk("win_mean_abs", 32'(vif.win_mean_abs), 32'(m_mean));
      chk("win_count", 32'(vif.win_count), 32'(m_count));
      chk("alarm", 32'(vif.alarm), 32'(m_alarm));
    end
  end

  // Record each result pulse for the directed literal checks.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (vif.win_valid === 1'b1) begin
        wins++;
        cap_p2p   = vif.win_p2p;
        cap_mean  = vif.win_mean_abs;
        cap_count = vif.win_count;
      end
    end
  end

  task automatic strobe(input int x, input int len);
    vif.in_data  = 8'(x);
    vif.in_valid = 1'b1;
    repeat (len) @(negedge clk);
    vif.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    vif.in_valid  = 1'b0;
    vif.in_data   = 8'd0;
    vif.enable    = 1'b1;
    vif.alarm_clr = 1'b0;
    model_reset();

    // Power-on reset, then long idle with no strobes.
    idle(3);
    rst_n = 1'b1;
    #1;
    chk("por_valid", 32'(vif.win_valid), 32'd0);
    chk("por_p2p", 32'(vif.win_p2p), 32'd0);
    chk("por_mean", 32'(vif.win_mean_abs), 32'd0);
    chk("por_count", 32'(vif.win_count), 32'd0);
    chk("por_alarm", 32'(vif.alarm), 32'd0);
    idle(100);
    chk("idle_nowin", 32'(wins), 32'd0);

    // 10, -20, 30, -40: p2p 70, mean 25, alarm set.
    base = wins;
    strobe(10, 1); strobe(-20, 1); strobe(30, 1); strobe(-40, 1);
    idle(2);
    chk("w1_pulses", 32'(wins - base), 32'd1);
    chk("w1_p2p", 32'(cap_p2p), 32'd70);
    chk("w1_mean", 32'(cap_mean), 32'd25);
    chk("w1_count", 32'(cap_count), 32'd1);
    chk("w1_alarm", 32'(vif.alarm), 32'd1);

    // Lone clear pulse.
    vif.alarm_clr = 1'b1;
    idle(1);
    vif.alarm_clr = 1'b0;
    idle(1);
    chk("clr_alarm", 32'(vif.alarm), 32'd0);

    // Four -128: exact magnitude 128, no spread.
    repeat (4) strobe(-128, 1);
    idle(2);
    chk("m128_mean", 32'(cap_mean), 32'd128);
    chk("m128_p2p", 32'(cap_p2p), 32'd0);
    chk("m128_alarm", 32'(vif.alarm), 32'd0);
    strobe(127, 1); strobe(-128, 1); strobe(0, 1); strobe(0, 1);
    idle(2);
    chk("full_p2p", 32'(cap_p2p), 32'd255);
    chk("full_mean", 32'(cap_mean), 32'd63);

    // Long strobe counts as one sample.
    base = wins;
    strobe(50, 5);
    repeat (3) strobe(50, 1);
    idle(2);
    chk("long_pulses", 32'(wins - base), 32'd1);
    chk("long_mean", 32'(cap_mean), 32'd50);
    chk("long_p2p", 32'(cap_p2p), 32'd0);

    // Enable drop discards a partial window.
    do_reset();
    idle(1);
    base = wins;
    strobe(1, 1); strobe(2, 1);
    vif.enable = 1'b0;
    idle(2);
    vif.enable = 1'b1;
    repeat (4) strobe(5, 1);
    idle(2);
    chk("abort_pulses", 32'(wins - base), 32'd1);
    chk("abort_mean", 32'(cap_mean), 32'd5);
    chk("abort_count", 32'(cap_count), 32'd1);

    // Set beats a simultaneous clear.
    strobe(10, 1); strobe(-20, 1); strobe(30, 1); strobe(-40, 1);
    strobe(10, 1); strobe(-20, 1); strobe(30, 1);
    vif.in_data   = 8'(-40);
    vif.in_valid  = 1'b1;
    vif.alarm_clr = 1'b1;
    idle(1);
    vif.in_valid  = 1'b0;
    vif.alarm_clr = 1'b0;
    idle(2);
    chk("setwins_alarm", 32'(vif.alarm), 32'd1);
    chk("setwins_p2p", 32'(cap_p2p), 32'd70);

    // Reset mid-window with the strobe held high across release.
    strobe(1, 1); strobe(2, 1);
    base = wins;
    vif.in_data  = 8'd7;
    vif.in_valid = 1'b1;
    do_reset();
    idle(3);
    vif.in_valid = 1'b0;
    idle(1);
    chk("rst_nopulse", 32'(wins - base), 32'd0);
    repeat (4) strobe(9, 1);
    idle(2);
    chk("rst_pulses", 32'(wins - base), 32'd1);
    chk("rst_mean", 32'(cap_mean), 32'd9);
    chk("rst_count", 32'(cap_count), 32'd1);

    // Randomized strobes, enable drops and clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        vif.enable = 1'b0;
        idle(int'($urandom_range(1, 3)));
        vif.enable = 1'b1;
      end
      vif.alarm_clr = ($urandom_range(0, 7) == 0);
      strobe(int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      vif.alarm_clr = 1'b0;
      idle(int'($urandom_range(0, 1)));
    end
    idle(3);

    // Counter wrap: preset near the top instead of running 65536 windows.
    m_count = 16'hFFFE;
    force dut.count_q = 16'hFFFE;
    #2;
    release dut.count_q;
    idle(2);
    repeat (4) strobe(3, 1);
    idle(2);
    chk("wrap_ffff", 32'(cap_count), 32'hFFFF);
    repeat (4) strobe(3, 1);
    idle(2);
    chk("wrap_zero", 32'(cap_count), 32'h0000);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
